// File: rtl/ifu_fetch.sv
// Instruction-fetch front end: holds the PC, issues single-word reads to sram_bridge,
// and presents each fetched word to decode over a valid/ready handshake.
`timescale 1ns/1ps
module ifu_fetch #(
  parameter int unsigned       XLEN     = 32,
  parameter logic [XLEN-1:0]   RESET_PC = 32'h8000_0000
) (
  input  logic            clock,
  input  logic            reset,
  output logic            sram_valid,
  output logic [XLEN-1:0] sram_addr,
  input  logic [XLEN-1:0] sram_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_inst,
  output logic [XLEN-1:0] out_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] fetch_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t          state, state_n;
  logic [XLEN-1:0] pc, pc_n;
  logic            out_valid_n;
  logic [XLEN-1:0] out_inst_n, out_pc_n, fetch_cnt_n;

  assign sram_addr = {pc[XLEN-1:2], 2'b00};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      pc        <= RESET_PC;
      out_valid <= 1'b0;
      out_inst  <= '0;
      out_pc    <= RESET_PC;
      fetch_cnt <= '0;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      out_valid <= out_valid_n;
      out_inst  <= out_inst_n;
      out_pc    <= out_pc_n;
      fetch_cnt <= fetch_cnt_n;
    end
  end

  always_comb begin
    state_n     = state;
    pc_n        = pc;
    out_valid_n = out_valid;
    out_inst_n  = out_inst;
    out_pc_n    = out_pc;
    fetch_cnt_n = fetch_cnt;
    sram_valid  = 1'b0;
    case (state)
      S_IDLE: begin
        if (redirect_valid) pc_n = redirect_pc;
        state_n = S_REQ;
      end
      S_REQ: begin
        // A redirect suppresses the request so the old PC is never read.
        sram_valid = ~redirect_valid;
        if (redirect_valid) pc_n = redirect_pc;
        else                state_n = S_WAIT;
      end
      S_WAIT: begin
        if (redirect_valid) begin
          pc_n    = redirect_pc;
          state_n = S_REQ;
        end else begin
          out_inst_n  = sram_data;
          out_pc_n    = pc;
          out_valid_n = 1'b1;
          state_n     = S_HOLD;
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          out_valid_n = 1'b0;
          fetch_cnt_n = fetch_cnt + XLEN'(1);
          pc_n        = redirect_valid ? redirect_pc : pc + XLEN'(4);
          state_n     = S_REQ;
        end else if (redirect_valid) begin
          out_valid_n = 1'b0;
          pc_n        = redirect_pc;
          state_n     = S_REQ;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed self-checking bench for ifu_fetch with a one-cycle-latency memory responder.
`timescale 1ns/1ps
module tb_ifu_fetch;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        sram_valid;
  logic [31:0] sram_addr;
  logic [31:0] sram_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_inst, out_pc;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] fetch_cnt;

  int unsigned vectors = 0;
  int unsigned errors  = 0;

  ifu_fetch #(.XLEN(32), .RESET_PC(32'h8000_0000)) dut (
    .clock(clock), .reset(reset),
    .sram_valid(sram_valid), .sram_addr(sram_addr), .sram_data(sram_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_pc(out_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fetch_cnt(fetch_cnt)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h8000_0000) return 32'h0000_0413;
    return a ^ 32'hA5A5_0000;
  endfunction

  // Memory answers in the cycle after the request edge; junk otherwise.
  always @(posedge clock) begin
    if (sram_valid) sram_data <= mem_word(sram_addr);
    else            sram_data <= 32'hDEAD_BEEF;
  end

  task automatic tick;
    @(negedge clock);
  endtask

  task automatic test_reset;
    tick; tick;
    vectors++; if (sram_valid !== 1'b0) begin errors++; $display("FAIL rst_sram_valid got %0h want 0", sram_valid); end
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %0h want 0", out_valid); end
    vectors++; if (out_inst !== 32'h0) begin errors++; $display("FAIL rst_out_inst got %08h want 0", out_inst); end
    vectors++; if (out_pc !== 32'h8000_0000) begin errors++; $display("FAIL rst_out_pc got %08h want 80000000", out_pc); end
    vectors++; if (fetch_cnt !== 32'h0) begin errors++; $display("FAIL rst_fetch_cnt got %0d want 0", fetch_cnt); end
    vectors++; if (sram_addr !== 32'h8000_0000) begin errors++; $display("FAIL rst_sram_addr got %08h want 80000000", sram_addr); end
  endtask

  // Release reset and follow the first fetch through to the next request.
  task automatic test_first_fetch(input logic [31:0] exp_cnt_after);
    reset = 1'b1;
    tick;
    vectors++; if (sram_valid !== 1'b1) begin errors++; $display("FAIL first_req_valid got %0h want 1", sram_valid); end
    vectors++; if (sram_addr !== 32'h8000_0000) begin errors++; $display("FAIL first_req_addr got %08h want 80000000", sram_addr); end
    tick;
    vectors++; if (sram_valid !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL first_wait got sv=%0h ov=%0h want 0 0", sram_valid, out_valid); end
    tick;
    vectors++; if (out_valid !== 1'b1) begin errors++; $display("FAIL first_out_valid got %0h want 1", out_valid); end
    vectors++; if (out_inst !== 32'h0000_0413) begin errors++; $display("FAIL first_out_inst got %08h want 00000413", out_inst); end
    vectors++; if (out_pc !== 32'h8000_0000) begin errors++; $display("FAIL first_out_pc got %08h want 80000000", out_pc); end
    vectors++; if (fetch_cnt !== exp_cnt_after - 1) begin errors++; $display("FAIL first_cnt_hold got %0d want %0d", fetch_cnt, exp_cnt_after - 1); end
    tick;
    vectors++; if (sram_valid !== 1'b1 || sram_addr !== 32'h8000_0004) begin errors++; $display("FAIL second_req got sv=%0h addr=%08h want 1 80000004", sram_valid, sram_addr); end
    vectors++; if (fetch_cnt !== exp_cnt_after) begin errors++; $display("FAIL first_cnt got %0d want %0d", fetch_cnt, exp_cnt_after); end
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL first_out_drop got %0h want 0", out_valid); end
  endtask

  // Entered in REQ at pc 0x8000_0004 with fetch_cnt == 1.
  task automatic test_hold_stall;
    out_ready = 1'b0;
    tick; tick;
    vectors++; if (out_valid !== 1'b1 || out_pc !== 32'h8000_0004) begin errors++; $display("FAIL stall_enter got ov=%0h pc=%08h want 1 80000004", out_valid, out_pc); end
    for (int i = 0; i < 5; i++) begin
      tick;
      vectors++;
      if (out_valid !== 1'b1 || out_inst !== mem_word(32'h8000_0004) || out_pc !== 32'h8000_0004 ||
          sram_valid !== 1'b0 || fetch_cnt !== 32'd1) begin
        errors++;
        $display("FAIL stall_cycle%0d got ov=%0h inst=%08h pc=%08h sv=%0h cnt=%0d want 1 %08h 80000004 0 1",
                 i, out_valid, out_inst, out_pc, sram_valid, fetch_cnt, mem_word(32'h8000_0004));
      end
    end
    out_ready = 1'b1;
    tick;
    vectors++; if (fetch_cnt !== 32'd2) begin errors++; $display("FAIL stall_release_cnt got %0d want 2", fetch_cnt); end
    vectors++; if (sram_valid !== 1'b1 || sram_addr !== 32'h8000_0008) begin errors++; $display("FAIL stall_next_req got sv=%0h addr=%08h want 1 80000008", sram_valid, sram_addr); end
  endtask

  // Entered in REQ at pc 0x8000_0008, fetch_cnt == 2.
  task automatic test_redirect_hold;
    tick; tick;
    vectors++; if (out_valid !== 1'b1 || out_pc !== 32'h8000_0008) begin errors++; $display("FAIL rh_hold got ov=%0h pc=%08h want 1 80000008", out_valid, out_pc); end
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0100; out_ready = 1'b1;
    tick;
    redirect_valid = 1'b0;
    #1;
    vectors++; if (fetch_cnt !== 32'd3) begin errors++; $display("FAIL rh_cnt got %0d want 3", fetch_cnt); end
    vectors++; if (sram_valid !== 1'b1 || sram_addr !== 32'h8000_0100) begin errors++; $display("FAIL rh_next_req got sv=%0h addr=%08h want 1 80000100", sram_valid, sram_addr); end
  endtask

  // Entered just after a negedge in REQ at pc 0x8000_0100, fetch_cnt == 3.
  task automatic test_redirect_wait;
    tick;
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0202;
    tick;
    redirect_valid = 1'b0;
    #1;
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rw_no_present got %0h want 0", out_valid); end
    vectors++; if (sram_valid !== 1'b1 || sram_addr !== 32'h8000_0200) begin errors++; $display("FAIL rw_next_req got sv=%0h addr=%08h want 1 80000200", sram_valid, sram_addr); end
    tick;
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rw_wait_ov got %0h want 0", out_valid); end
    tick;
    vectors++; if (out_valid !== 1'b1 || out_inst !== mem_word(32'h8000_0200)) begin errors++; $display("FAIL rw_inst got ov=%0h inst=%08h want 1 %08h", out_valid, out_inst, mem_word(32'h8000_0200)); end
    vectors++; if (out_pc !== 32'h8000_0202) begin errors++; $display("FAIL rw_out_pc got %08h want 80000202", out_pc); end
    vectors++; if (fetch_cnt !== 32'd3) begin errors++; $display("FAIL rw_cnt got %0d want 3", fetch_cnt); end
    tick;
    vectors++; if (sram_addr !== 32'h8000_0204 || fetch_cnt !== 32'd4) begin errors++; $display("FAIL rw_after got addr=%08h cnt=%0d want 80000204 4", sram_addr, fetch_cnt); end
  endtask

  // Entered at a negedge in REQ at pc 0x8000_0206.
  task automatic test_redirect_req;
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0300;
    #1;
    vectors++; if (sram_valid !== 1'b0) begin errors++; $display("FAIL rr_suppress got %0h want 0", sram_valid); end
    tick;
    redirect_valid = 1'b0;
    #1;
    vectors++; if (sram_valid !== 1'b1 || sram_addr !== 32'h8000_0300) begin errors++; $display("FAIL rr_next_req got sv=%0h addr=%08h want 1 80000300", sram_valid, sram_addr); end
    tick;
  endtask

  // Entered in WAIT with nonzero outputs/counter; reset mid-cycle.
  task automatic test_reset_wait;
    #2 reset = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || out_inst !== 32'h0 || out_pc !== 32'h8000_0000 || fetch_cnt !== 32'h0 ||
        sram_valid !== 1'b0 || sram_addr !== 32'h8000_0000) begin
      errors++;
      $display("FAIL async_reset got ov=%0h inst=%08h pc=%08h cnt=%0d sv=%0h addr=%08h want 0 0 80000000 0 0 80000000",
               out_valid, out_inst, out_pc, fetch_cnt, sram_valid, sram_addr);
    end
    tick; tick;
    vectors++; if (out_valid !== 1'b0 || sram_valid !== 1'b0) begin errors++; $display("FAIL reset_held got ov=%0h sv=%0h want 0 0", out_valid, sram_valid); end
    test_first_fetch(32'd1);
  endtask

  // Entered in REQ at pc 0x8000_0004, fetch_cnt == 1.
  task automatic test_pc_wrap;
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick;
    redirect_valid = 1'b0;
    #1;
    vectors++; if (sram_valid !== 1'b1 || sram_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_req got sv=%0h addr=%08h want 1 fffffffc", sram_valid, sram_addr); end
    tick; tick;
    vectors++; if (out_pc !== 32'hFFFF_FFFC || out_inst !== mem_word(32'hFFFF_FFFC)) begin errors++; $display("FAIL wrap_out got pc=%08h inst=%08h want fffffffc %08h", out_pc, out_inst, mem_word(32'hFFFF_FFFC)); end
    tick;
    vectors++; if (sram_addr !== 32'h0000_0000 || fetch_cnt !== 32'd2) begin errors++; $display("FAIL wrap_next got addr=%08h cnt=%0d want 00000000 2", sram_addr, fetch_cnt); end
  endtask

  initial begin
    test_reset;
    test_first_fetch(32'd1);
    test_hold_stall;
    test_redirect_hold;
    test_redirect_wait;
    test_redirect_req;
    test_reset_wait;
    test_pc_wrap;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired got timeout want completion");
    $fatal(1);
  end

endmodule
